// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 fetch/sequencing slice.
// The HALT_BUG_EN build macro (see fetch_sequencer.sv) adds no package content.
package sm83_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_HALT  = 3'd2,
        ST_STOP  = 3'd3,
        ST_IRQ   = 3'd4
    } fetch_state_t;

    localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
    localparam logic [15:0] IRQ_VEC_STRIDE = 16'd8;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    function automatic logic [15:0] irq_vec(input logic [7:0] idx);
        return IRQ_VEC_BASE + (16'(idx) * IRQ_VEC_STRIDE);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Opcode-fetch memory port between the fetch sequencer (master) and the bus unit (slave).
// Handshake: mem_req with mem_addr is held stable until a cycle where mem_ack=1; that
// cycle completes the transfer with mem_rdata valid. mem_ack without mem_req is meaningless.
interface fetch_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_sequencer_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins (index 0 = highest priority).
module irq_prio_enc #(
    parameter int W     = 5,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-boundary controller: PC/IR ownership, opcode fetch, HALT/STOP, IME and IRQ dispatch.
// Build macro HALT_BUG_EN: HALT with IME clear and an interrupt already pending re-executes the next byte.
module fetch_sequencer
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IRQ_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master mem,
    output logic [7:0]        ir,
    output logic              ir_valid,
    output logic              is_instr16,
    input  logic              dec_prefix,
    input  logic              dec_halt,
    input  logic              dec_stop,
    input  logic              dec_ei,
    input  logic              dec_di,
    input  logic              dec_reti,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [15:0]       pc_load_val,
    output logic [15:0]       pc,
    input  logic [IRQ_W-1:0]  irq_pending,
    output logic              irq_take,
    output logic [15:0]       irq_vector,
    output logic [IRQ_W-1:0]  irq_ack,
    input  logic              wake,
    output logic              ime,
    output fetch_state_t      state_dbg
);
    localparam int IDX_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;

    fetch_state_t     state, state_nxt;
    logic             ei_delay;
    logic             skip_inc;
    logic             ime_eff;
    logic             halt_bug;
    logic             prefix_step;
    logic             irq_enter;
    logic [IRQ_W-1:0] enc_onehot;
    logic [IDX_W-1:0] enc_idx;
    logic             irq_any;

    irq_prio_enc #(.W(IRQ_W), .IDX_W(IDX_W)) u_prio (
        .req    (irq_pending),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .any    (irq_any)
    );

    assign mem.mem_req  = (state == ST_FETCH);
    assign mem.mem_addr = pc;
    assign irq_take     = (state == ST_IRQ);
    assign state_dbg    = state;
    assign prefix_step  = (state == ST_EXEC) && dec_prefix && !is_instr16;
    assign irq_enter    = (state_nxt == ST_IRQ) && (state != ST_IRQ);

    always_comb begin
        state_nxt = state;
        ime_eff   = ime;
        halt_bug  = 1'b0;
        if (dec_di)                 ime_eff = 1'b0;
        else if (dec_ei)            ime_eff = ime;
        else if (ei_delay || dec_reti) ime_eff = 1'b1;
        case (state)
            ST_FETCH: if (mem.mem_ack) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (prefix_step) begin
                    state_nxt = ST_FETCH;
                end else if (exec_done) begin
                    if (dec_halt) begin
`ifdef HALT_BUG_EN
                        halt_bug = !ime && irq_any;
`else
                        halt_bug = 1'b0;
`endif
                        state_nxt = halt_bug ? ST_FETCH : ST_HALT;
                    end else if (dec_stop) begin
                        state_nxt = ST_STOP;
                    end else if (ime_eff && irq_any) begin
                        state_nxt = ST_IRQ;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALT:  if (irq_any) state_nxt = ime ? ST_IRQ : ST_FETCH;
            ST_STOP:  if (wake) state_nxt = ST_FETCH;
            ST_IRQ:   if (exec_done) state_nxt = ST_FETCH;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= 8'h00;
            ir_valid   <= 1'b0;
            is_instr16 <= 1'b0;
            ime        <= 1'b0;
            ei_delay   <= 1'b0;
            skip_inc   <= 1'b0;
            irq_ack    <= '0;
            irq_vector <= 16'h0000;
        end else begin
            state   <= state_nxt;
            irq_ack <= '0;
            case (state)
                ST_FETCH: begin
                    if (mem.mem_ack) begin
                        ir       <= mem.mem_rdata;
                        ir_valid <= 1'b1;
                        if (skip_inc) skip_inc <= 1'b0;
                        else          pc       <= pc + 16'd1;
                    end
                end
                ST_EXEC: begin
                    if (prefix_step) begin
                        is_instr16 <= 1'b1;
                        ir_valid   <= 1'b0;
                    end else if (exec_done) begin
                        is_instr16 <= 1'b0;
                        ir_valid   <= 1'b0;
                        if (pc_load) pc <= pc_load_val;
                        if (dec_di) begin
                            ime      <= 1'b0;
                            ei_delay <= 1'b0;
                        end else if (dec_ei) begin
                            ei_delay <= 1'b1;
                        end else if (ei_delay) begin
                            ime      <= 1'b1;
                            ei_delay <= 1'b0;
                        end else if (dec_reti) begin
                            ime <= 1'b1;
                        end
                        if (halt_bug) skip_inc <= 1'b1;
                    end
                end
                ST_IRQ: if (exec_done) pc <= irq_vector;
                default: ;
            endcase
            // Dispatch entry wins over any IME update made at the same boundary.
            if (irq_enter) begin
                irq_ack    <= enc_onehot;
                irq_vector <= irq_vec(8'(enc_idx));
                ime        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer with an instruction-level reference model.
module tb_fetch_sequencer;
    import sm83_pkg::*;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h76;
    localparam logic [7:0] OP_STOP = 8'h10;
    localparam logic [7:0] OP_EI   = 8'hFB;
    localparam logic [7:0] OP_DI   = 8'hF3;
    localparam logic [7:0] OP_RETI = 8'hD9;
    localparam logic [7:0] OP_CB   = 8'hCB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   ir;
    logic         ir_valid, is_instr16;
    logic         dec_prefix = 0, dec_halt = 0, dec_stop = 0, dec_ei = 0, dec_di = 0, dec_reti = 0;
    logic         exec_done = 0, pc_load = 0;
    logic [15:0]  pc_load_val = 16'h0000;
    logic [15:0]  pc;
    logic [4:0]   irq_pending = 5'b0;
    logic         irq_take;
    logic [15:0]  irq_vector;
    logic [4:0]   irq_ack;
    logic         wake = 1'b0;
    logic         ime;
    fetch_state_t state_dbg;

    fetch_sequencer_if mem_bus();

    fetch_sequencer #(.RESET_PC(16'h0000), .IRQ_W(5)) dut (
        .clk(clk), .rst(rst), .mem(mem_bus),
        .ir(ir), .ir_valid(ir_valid), .is_instr16(is_instr16),
        .dec_prefix(dec_prefix), .dec_halt(dec_halt), .dec_stop(dec_stop),
        .dec_ei(dec_ei), .dec_di(dec_di), .dec_reti(dec_reti),
        .exec_done(exec_done), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc(pc), .irq_pending(irq_pending), .irq_take(irq_take),
        .irq_vector(irq_vector), .irq_ack(irq_ack), .wake(wake), .ime(ime),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural PC, IME, pending-EI, CB second byte, halt-bug replay.
    logic [15:0] m_pc = 16'h0000;
    bit m_ime = 0, m_eid = 0, m_second = 0, m_skip = 0, drop_next = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_dec();
        dec_prefix = 0; dec_halt = 0; dec_stop = 0; dec_ei = 0; dec_di = 0; dec_reti = 0;
    endtask

    task automatic set_dec(input logic [7:0] b);
        dec_prefix = !m_second && b == OP_CB;
        dec_halt   = !m_second && b == OP_HALT;
        dec_stop   = !m_second && b == OP_STOP;
        dec_ei     = !m_second && b == OP_EI;
        dec_di     = !m_second && b == OP_DI;
        dec_reti   = !m_second && b == OP_RETI;
    endtask

    task automatic fetch_byte(input logic [7:0] b, input int lat);
        int n;
        n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 16'(mem_bus.mem_req), 16'd1);
        chk("fetch_addr", mem_bus.mem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("addr_hold", mem_bus.mem_addr, m_pc);
        end
        mem_bus.mem_rdata = b;
        mem_bus.mem_ack   = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'($urandom);
        chk("ir", 16'(ir), 16'(b));
        chk("ir_valid", 16'(ir_valid), 16'd1);
        chk("is_instr16", 16'(is_instr16), 16'(m_second));
        if (m_skip) m_skip = 0;
        else        m_pc   = m_pc + 16'd1;
        chk("pc_after_fetch", pc, m_pc);
    endtask

    task automatic expect_dispatch();
        int idx;
        logic [15:0] vec;
        idx = -1;
        for (int i = 4; i >= 0; i--) if (irq_pending[i]) idx = i;
        vec = 16'h0040 + 16'(idx * 8);
        chk("irq_take", 16'(irq_take), 16'd1);
        chk("irq_vector", irq_vector, vec);
        chk("irq_ack", 16'(irq_ack), 16'(5'b1 << idx));
        chk("ime_in_irq", 16'(ime), 16'd0);
        chk("irq_no_req", 16'(mem_bus.mem_req), 16'd0);
        if (drop_next) begin
            irq_pending[0] = 1'b0;
            drop_next = 0;
        end
        @(negedge clk);
        chk("irq_ack_pulse", 16'(irq_ack), 16'd0);
        chk("irq_vector_hold", irq_vector, vec);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        irq_pending[idx] = 1'b0;
        m_pc  = vec;
        m_ime = 0;
        chk("irq_exit_take", 16'(irq_take), 16'd0);
        chk("irq_exit_pc", pc, m_pc);
    endtask

    task automatic finish_instr(input logic [7:0] b, input bit load, input logic [15:0] tgt);
        logic [7:0] kind;
        bit eff, disp, ime_before;
        int d;
        set_dec(b);
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("exec_ir_valid", 16'(ir_valid), 16'd1);
            chk("exec_no_req", 16'(mem_bus.mem_req), 16'd0);
        end
        exec_done = 1'b1; pc_load = load; pc_load_val = tgt;
        @(negedge clk);
        exec_done = 1'b0; pc_load = 1'b0; pc_load_val = 16'($urandom);
        clear_dec();
        kind = m_second ? OP_NOP : b;
        m_second = 0;
        ime_before = m_ime;
        if (load) m_pc = tgt;
        eff = m_ime;
        if (kind == OP_DI) begin
            m_ime = 0; m_eid = 0; eff = 0;
        end else if (kind == OP_EI) begin
            m_eid = 1;
        end else if (m_eid || kind == OP_RETI) begin
            m_ime = 1; m_eid = 0; eff = 1;
        end
`ifdef HALT_BUG_EN
        if (kind == OP_HALT && !ime_before && irq_pending != 0) m_skip = 1;
`endif
        disp = kind != OP_HALT && kind != OP_STOP && eff && irq_pending != 0;
        if (disp) m_ime = 0;
        chk("done_pc", pc, m_pc);
        chk("done_ime", 16'(ime), 16'(m_ime));
        chk("done_ir_valid", 16'(ir_valid), 16'd0);
        chk("done_is_instr16", 16'(is_instr16), 16'd0);
        if (disp) expect_dispatch();
    endtask

    task automatic run_instr(input logic [7:0] b, input int lat, input bit load, input logic [15:0] tgt);
        fetch_byte(b, lat);
        finish_instr(b, load, tgt);
    endtask

    initial begin
        int req_cnt;
        logic [7:0] rb;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", 16'(ir), 16'h0000);
        chk("rst_ir_valid", 16'(ir_valid), 16'd0);
        chk("rst_ime", 16'(ime), 16'd0);
        chk("rst_irq_take", 16'(irq_take), 16'd0);
        chk("rst_irq_ack", 16'(irq_ack), 16'd0);
        chk("rst_irq_vector", irq_vector, 16'h0000);
        chk("rst_is_instr16", 16'(is_instr16), 16'd0);
        rst = 1'b0;

        // Two single-cycle NOP fetches
        run_instr(OP_NOP, 0, 0, 16'h0);
        run_instr(OP_NOP, 0, 0, 16'h0);
        chk("pc_two_nops", pc, 16'h0002);

        // CB prefix: second fetch without exec_done
        fetch_byte(OP_CB, 0);
        set_dec(OP_CB);
        m_second = 1;
        @(negedge clk);
        clear_dec();
        chk("cb_is_instr16", 16'(is_instr16), 16'd1);
        chk("cb_refetch_req", 16'(mem_bus.mem_req), 16'd1);
        fetch_byte(8'h37, 1);
        finish_instr(8'h37, 0, 16'h0);

        // EI delay then timer dispatch
        run_instr(OP_NOP, 1, 1, 16'h0100);
        irq_pending = 5'b00100;
        run_instr(OP_EI, 0, 0, 16'h0);
        chk("ei_no_dispatch", 16'(irq_take), 16'd0);
        run_instr(OP_NOP, 0, 0, 16'h0);
        chk("after_dispatch_addr", mem_bus.mem_addr, 16'h0050);

        // Priority and latched vector with ime=1
        irq_pending = 5'b0;
        run_instr(OP_EI, 0, 0, 16'h0);
        run_instr(OP_NOP, 0, 0, 16'h0);
        irq_pending = 5'b10011;
        drop_next = 1;
        run_instr(OP_NOP, 2, 0, 16'h0);
        irq_pending = 5'b0;

        // HALT with ime=0: wake on pending, no dispatch
        run_instr(OP_HALT, 0, 0, 16'h0);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_bus.mem_req) req_cnt++;
        end
        chk("halt_idle", 16'(req_cnt), 16'd0);
        irq_pending = 5'b00001;
        @(negedge clk);
        chk("halt_exit_req", 16'(mem_bus.mem_req), 16'd1);
        chk("halt_exit_addr", mem_bus.mem_addr, m_pc);
        chk("halt_exit_take", 16'(irq_take), 16'd0);
        run_instr(OP_NOP, 0, 0, 16'h0);
        irq_pending = 5'b0;

        // HALT with interrupt already pending and ime=0
        irq_pending = 5'b00010;
        run_instr(OP_HALT, 0, 0, 16'h0);
        run_instr(8'h3C, 0, 0, 16'h0);
        run_instr(8'h3C, 0, 0, 16'h0);
        irq_pending = 5'b0;

        // STOP ignores pending, exits on wake
        run_instr(OP_EI, 0, 0, 16'h0);
        run_instr(OP_NOP, 0, 0, 16'h0);
        irq_pending = 5'b11111;
        run_instr(OP_STOP, 0, 0, 16'h0);
        req_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_bus.mem_req || irq_take) req_cnt++;
        end
        chk("stop_idle", 16'(req_cnt), 16'd0);
        wake = 1'b1;
        @(negedge clk);
        wake = 1'b0;
        chk("stop_wake_req", 16'(mem_bus.mem_req), 16'd1);
        run_instr(OP_DI, 0, 0, 16'h0);
        irq_pending = 5'b0;

        // PC wrap
        run_instr(OP_NOP, 0, 1, 16'hFFFF);
        run_instr(OP_NOP, 1, 0, 16'h0);
        chk("pc_wrap", pc, 16'h0000);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            irq_pending = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            case ($urandom_range(0, 9))
                0: rb = OP_EI;
                1: rb = OP_DI;
                2: rb = OP_RETI;
                default: begin
                    rb = 8'($urandom);
                    while (rb == OP_CB || rb == OP_HALT || rb == OP_STOP || rb == OP_EI ||
                           rb == OP_DI || rb == OP_RETI) rb = 8'($urandom);
                end
            endcase
            run_instr(rb, $urandom_range(0, 2), $urandom_range(0, 3) == 0, 16'($urandom));
        end
        irq_pending = 5'b0;

        // Reset during a fetch with ack in the same cycle
        rst = 1'b1;
        mem_bus.mem_rdata = 8'hA5;
        mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("rst_mid_ir", 16'(ir), 16'h0000);
        chk("rst_mid_pc", pc, 16'h0000);
        chk("rst_mid_ir_valid", 16'(ir_valid), 16'd0);
        chk("rst_mid_ime", 16'(ime), 16'd0);
        rst = 1'b0;
        m_pc = 16'h0000; m_ime = 0; m_eid = 0; m_second = 0; m_skip = 0;
        run_instr(OP_NOP, 0, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-boundary controller for the SM83 core. It owns PC and the instruction register, and issues opcode-byte fetches over a req/ack memory handshake. It feeds the decoder (IR plus the CB-prefix flag that drives the decoder's second-byte input), and sequences HALT/STOP low-power states, IME/EI delay and interrupt dispatch. It sits between the bus interface and decode/execute.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
IRQ_W, 5, number of interrupt sources (index 0 = highest priority)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
mem_req  out  1  opcode fetch request
mem_addr  out  16  fetch address (= pc)
mem_rdata  in  8  fetched byte
mem_ack  in  1  fetch complete; ignored unless mem_req=1
ir  out  8  instruction register to decode
ir_valid  out  1  ir holds a byte awaiting execution
is_instr16  out  1  ir is the second byte of a CB-prefixed instruction
dec_prefix  in  1  decoder flags ir as the CB prefix (0xCB)
dec_halt  in  1  decoded op is HALT
dec_stop  in  1  decoded op is STOP
dec_ei  in  1  decoded op is EI
dec_di  in  1  decoded op is DI
dec_reti  in  1  decoded op is RETI
exec_done  in  1  executer finished the current instruction or dispatch
pc_load  in  1  executer redirect (jump/call/ret/rst); sampled with exec_done
pc_load_val  in  16  redirect target
pc  out  16  current PC
irq_pending  in  IRQ_W  IE & IF
irq_take  out  1  dispatch in progress (executer pushes pc)
irq_vector  out  16  dispatch target
irq_ack  out  IRQ_W  one-hot, 1-cycle pulse clearing the IF bit
wake  in  1  STOP exit (joypad)
ime  out  1  interrupt master enable

Behaviour:
- States: FETCH, EXEC, HALT, STOP, IRQ. rst -> state FETCH, pc=RESET_PC, ir=8'h00, ir_valid=0, is_instr16=0, ime=0, ei_delay=0, irq_take=0, irq_ack=0, irq_vector=16'h0000. Reset aborts an outstanding fetch; an ack in the reset cycle is ignored.
- FETCH: mem_req=1, mem_addr=pc, held stable until mem_ack. On ack: ir<=mem_rdata, pc<=pc+1 (16-bit wrap FFFF->0000), ->EXEC. Same-cycle ack gives 1-cycle fetch. mem_req=0 in all other states.
- EXEC: ir_valid=1.
  - If dec_prefix && !is_instr16: is_instr16<=1, ->FETCH with no exec_done needed and no interrupt check.
  - Otherwise wait for exec_done. On exec_done: is_instr16<=0, ir_valid<=0; pc<=pc_load_val if pc_load. Next state by priority: dec_halt->HALT; dec_stop->STOP; (ime_eff && |irq_pending)->IRQ; else FETCH.
- IME rules, evaluated at exec_done:
  - dec_di: ime<=0, ei_delay<=0, ime_eff=0.
  - dec_ei: ei_delay<=1, ime_eff=ime (no interrupt at this boundary if ime=0).
  - ei_delay=1 on a later instruction: ime<=1, ei_delay<=0, ime_eff=1.
  - dec_reti: ime<=1, ime_eff=1.
  - Otherwise ime_eff=ime.
- HALT: when |irq_pending: ->IRQ if ime, else ->FETCH (resume at pc). STOP: wake -> FETCH; irq_pending is ignored.
- IRQ: on entry latch idx = lowest set bit of irq_pending; irq_ack pulses bit idx for one cycle; ime<=0. irq_take=1 and irq_vector=16'h0040+8*idx are held while in IRQ. On exec_done: pc<=irq_vector, ->FETCH. Later changes to irq_pending do not alter the latched idx.
- pc_load outside exec_done is ignored.

Optional Feature:
HALT_BUG_EN. Defined: HALT taken with ime=0 and |irq_pending already set does not enter HALT; it goes to FETCH with a one-shot flag that suppresses the next pc increment, so the following byte executes twice. Undefined: HALT always enters HALT state and exits immediately the next cycle.

Decomposition:
- sm83_pkg: fetch_state_t enum; IRQ_VEC_BASE=16'h0040; IRQ_VEC_STRIDE=8; irq index constants (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4).
- Sub-module irq_prio_enc: IRQ_W-bit lowest-index priority encoder (one-hot out, index out, any out).

Test Plan:
- Reset, ir=0x00 at 0x0000, ack in 1 cycle -> mem_addr 0000, then 0001; ir_valid high one cycle before each exec_done; pc=0002 after 2 NOPs.
- Fetch 0xCB then 0x37 -> second fetch with no exec_done between; is_instr16=1 with ir=0x37; cleared on exec_done.
- EI at 0x0100, irq_pending=5'b00100 -> no dispatch after EI; dispatch after the next instruction; irq_vector=0x0050, irq_ack=00100 for one cycle, ime=0; after exec_done mem_addr=0x0050.
- irq_pending=5'b10011, ime=1 -> idx 0, vector 0x0040; drop bit 0 mid-IRQ -> vector unchanged.
- HALT, ime=0, irq_pending rises after 10 cycles -> resumes FETCH at HALT+1 with no dispatch; with HALT_BUG_EN and pending already set -> the byte at HALT+1 is fetched twice.
- pc=FFFF fetch -> pc wraps to 0000; rst asserted mid-FETCH with mem_ack=1 -> ir stays 0x00, pc=RESET_PC.
